axi4_lite_master_engine: RTL and testbench
==========================================

// Module: axi4_lite_master_engine
// PURPOSE
//  Synthesizable, parametrised AXI4-Lite master. Converts a valid/ready command stream into single
//  AXI4-Lite read or write transactions and returns the response on a valid/ready response stream.
//  Generalises the 32-bit fixed-strobe master: configurable data/address width, byte strobes,
//  full BRESP/RRESP reporting and a transaction watchdog. Sits between on-chip controllers and an
//  AXI4-Lite interconnect or slave.
// PARAMETERS
//  ADDR_WIDTH      32    address width of cmd_addr, m_awaddr, m_araddr
//  DATA_WIDTH      32    data width: 32 or 64 only; STRB_WIDTH = DATA_WIDTH/8
//  AWCACHE         4'h3  constant driven on m_awcache
//  ARCACHE         4'h2  constant driven on m_arcache
//  PROT            3'b000 constant driven on m_awprot and m_arprot
//  TIMEOUT_CYCLES  1024  watchdog limit in aclk cycles per transaction; 0 = watchdog disabled
// PORTS
//  aclk         in   1           clock, all logic on rising edge
//  aresetn      in   1           asynchronous active-low reset
//  cmd_valid    in   1           command present
//  cmd_ready    out  1           command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1           1 = write, 0 = read
//  cmd_addr     in   ADDR_WIDTH  transaction address
//  cmd_wdata    in   DATA_WIDTH  write data (ignored for reads)
//  cmd_wstrb    in   STRB_WIDTH  write byte strobes (ignored for reads)
//  rsp_valid    out  1           response present
//  rsp_ready    in   1           response consumed when rsp_valid & rsp_ready
//  rsp_write    out  1           response belongs to a write
//  rsp_rdata    out  DATA_WIDTH  read data (0 for writes)
//  rsp_resp     out  2           BRESP or RRESP as received
//  busy         out  1           1 whenever state != IDLE
//  timeout_err  out  1           sticky watchdog flag, cleared only by reset
//  m_aw*/m_w*/m_b*/m_ar*/m_r*    AXI4-Lite master channels (awaddr,awcache,awprot,awvalid,awready,
//                                wdata,wstrb,wvalid,wready,bresp,bvalid,bready,araddr,arcache,arprot,
//                                arvalid,arready,rdata,rresp,rvalid,rready), widths per parameters
// BEHAVIOUR
//  Reset (aresetn low, async): state IDLE; all valid/ready outputs 0 except cmd_ready=1; addr, wdata,
//   rsp_rdata, rsp_resp, rsp_write = 0; m_wstrb = 0; busy = 0; timeout_err = 0; watchdog counter = 0.
//   Reset mid-transaction abandons it silently; no response is produced.
//  Constant outputs m_awcache/m_arcache/m_awprot/m_arprot are driven from parameters at all times.
//  All outputs are registered. One transaction outstanding at a time; cmd_ready = (state == IDLE).
//  FSM: IDLE -> WR_REQ | RD_REQ on cmd accept; WR_REQ -> WR_RESP; RD_REQ -> RD_DATA; WR_RESP/RD_DATA -> RSP;
//   RSP -> IDLE on rsp handshake.
//  IDLE: command accepted in cycle N, addr/data/strb captured; AXI valids rise in cycle N+1.
//  WR_REQ: m_awvalid and m_wvalid rise together; each falls the cycle after its own handshake,
//   independently (AW before W, W before AW, or both in the same cycle are all legal). Payload is held
//   stable while its valid is high. Leave WR_REQ when both handshakes have completed.
//  WR_RESP: m_bready = 1; on bvalid&bready capture bresp, m_bready falls, go to RSP.
//  RD_REQ: m_arvalid = 1 until arvalid&arready, then go to RD_DATA. RD_DATA: m_rready = 1; on
//   rvalid&rready capture rdata/rresp, go to RSP.
//  RSP: rsp_valid = 1 with the payload stable until rsp_ready; rsp_valid rises 1 cycle after the B/R
//   handshake. Back-to-back: a new cmd can be accepted the cycle after the rsp handshake.
//  Minimum latency (all slaves ready at once): cmd accept N -> AW/W or AR handshake N+1 -> B/R
//   handshake N+2 at earliest -> rsp_valid N+3.
//  Protocol: a valid is never withdrawn before its handshake. bvalid/rvalid seen outside
//   WR_RESP/RD_DATA are ignored.
//  Watchdog: counter clears on cmd accept and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA,
//   saturating at TIMEOUT_CYCLES. Reaching it sets timeout_err; the transaction keeps waiting with no
//   protocol violation. The counter is inactive when TIMEOUT_CYCLES = 0.
//  Strobes pass through unchanged, including 0 (a legal no-op write). For reads, m_wstrb is not driven
//   from cmd_wstrb.
// TESTING
//  1 W32 write addr=0x10 data=0xDEADBEEF strb=4'hF, slave always ready, bresp=OKAY -> awvalid/wvalid
//    high 1 cycle, rsp_valid at N+3, rsp_resp=2'b00
//  2 W64 read addr=0x08, arready delayed 5 cycles, rdata=0x0123456789ABCDEF, rresp=SLVERR -> arvalid held
//    6 cycles, rsp_rdata matches, rsp_resp=2'b10
//  3 Write with wready 3 cycles after awready, then the reverse order -> each valid drops independently;
//    one bready pulse; one rsp
//  4 TIMEOUT_CYCLES=16, bvalid withheld 40 cycles -> timeout_err=1 at cycle 16, bready held, rsp still
//    delivered after bvalid; flag stays set
//  5 rsp_ready held low 10 cycles, then 2 queued cmds -> rsp payload stable, cmd_ready low until the
//    handshake, second cmd accepted the next cycle
//  6 aresetn asserted while in WR_REQ -> all valids 0 asynchronously, no rsp, next cmd completes normally

Source files
------------

// File: rtl/axi4_lite_master_engine_if.sv
// Command, response and AXI4-Lite channel bundle for the master engine.
// The master modport is the engine's view; slave is the environment's.
interface axi4_lite_master_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_wstrb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;

  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic [3:0]            m_awcache;
  logic [2:0]            m_awprot;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_WIDTH-1:0] m_wstrb;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [3:0]            m_arcache;
  logic [2:0]            m_arprot;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rvalid;
  logic                  m_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata,
    output rsp_resp,
    input  rsp_ready,
    output m_awaddr, m_awcache, m_awprot,
    output m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready,
    output m_araddr, m_arcache, m_arprot,
    output m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rvalid,
    output m_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata,
    input  rsp_resp,
    output rsp_ready,
    input  m_awaddr, m_awcache, m_awprot,
    input  m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready,
    input  m_araddr, m_arcache, m_arprot,
    input  m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/axi4_lite_master_engine.sv
// Single-outstanding AXI4-Lite master: one cmd becomes one AW/W/B or
// AR/R transaction, answered on the rsp stream. All outputs registered.
module axi4_lite_master_engine #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [3:0]  AWCACHE        = 4'h3,
  parameter logic [3:0]  ARCACHE        = 4'h2,
  parameter logic [2:0]  PROT           = 3'b000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axi4_lite_master_engine_if.master bus,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int WD_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

  typedef struct packed {
    logic                  cmd_ready;
    logic                  awvalid;
    logic                  wvalid;
    logic                  bready;
    logic                  arvalid;
    logic                  rready;
    logic                  rsp_valid;
    logic                  rsp_write;
    logic [1:0]            resp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  to_err;
    logic [WD_W-1:0]       wd_cnt;
  } regs_t;

  state_t state_q;
  state_t state_d;
  regs_t  r_q;
  regs_t  r_d;

  logic cmd_acc;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic rsp_hs;
  logic active;

  assign cmd_acc = bus.cmd_valid & r_q.cmd_ready;
  assign aw_hs   = r_q.awvalid & bus.m_awready;
  assign w_hs    = r_q.wvalid & bus.m_wready;
  assign b_hs    = bus.m_bvalid & r_q.bready;
  assign ar_hs   = r_q.arvalid & bus.m_arready;
  assign r_hs    = bus.m_rvalid & r_q.rready;
  assign rsp_hs  = r_q.rsp_valid & bus.rsp_ready;

  assign active = (state_q == WR_REQ) | (state_q == WR_RESP) |
                  (state_q == RD_REQ) | (state_q == RD_DATA);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      r_q         <= '0;
      r_q.cmd_ready <= 1'b1;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;

    // Watchdog saturates; the transaction keeps waiting regardless.
    if (TIMEOUT_CYCLES > 0 && active) begin
      if (r_q.wd_cnt != WD_MAX) begin
        r_d.wd_cnt = r_q.wd_cnt + WD_W'(1);
      end
      if (r_d.wd_cnt == WD_MAX) begin
        r_d.to_err = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          r_d.cmd_ready = 1'b0;
          r_d.busy      = 1'b1;
          r_d.wd_cnt    = '0;
          r_d.addr      = bus.cmd_addr;
          if (bus.cmd_write) begin
            r_d.wdata   = bus.cmd_wdata;
            r_d.wstrb   = bus.cmd_wstrb;
            r_d.awvalid = 1'b1;
            r_d.wvalid  = 1'b1;
            state_d     = WR_REQ;
          end else begin
            r_d.wdata   = '0;
            r_d.wstrb   = '0;
            r_d.arvalid = 1'b1;
            state_d     = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) r_d.awvalid = 1'b0;
        if (w_hs)  r_d.wvalid  = 1'b0;
        if (!r_d.awvalid && !r_d.wvalid) begin
          r_d.bready = 1'b1;
          state_d    = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          r_d.bready    = 1'b0;
          r_d.resp      = bus.m_bresp;
          r_d.rdata     = '0;
          r_d.rsp_write = 1'b1;
          r_d.rsp_valid = 1'b1;
          state_d       = RSP;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
          state_d     = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          r_d.rready    = 1'b0;
          r_d.resp      = bus.m_rresp;
          r_d.rdata     = bus.m_rdata;
          r_d.rsp_write = 1'b0;
          r_d.rsp_valid = 1'b1;
          state_d       = RSP;
        end
      end
      RSP: begin
        if (rsp_hs) begin
          r_d.rsp_valid = 1'b0;
          r_d.cmd_ready = 1'b1;
          r_d.busy      = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = r_q.cmd_ready;
  assign bus.rsp_valid = r_q.rsp_valid;
  assign bus.rsp_write = r_q.rsp_write;
  assign bus.rsp_rdata = r_q.rdata;
  assign bus.rsp_resp  = r_q.resp;

  assign bus.m_awaddr  = r_q.addr;
  assign bus.m_awcache = AWCACHE;
  assign bus.m_awprot  = PROT;
  assign bus.m_awvalid = r_q.awvalid;
  assign bus.m_wdata   = r_q.wdata;
  assign bus.m_wstrb   = r_q.wstrb;
  assign bus.m_wvalid  = r_q.wvalid;
  assign bus.m_bready  = r_q.bready;
  assign bus.m_araddr  = r_q.addr;
  assign bus.m_arcache = ARCACHE;
  assign bus.m_arprot  = PROT;
  assign bus.m_arvalid = r_q.arvalid;
  assign bus.m_rready  = r_q.rready;

  assign busy        = r_q.busy;
  assign timeout_err = r_q.to_err;
endmodule

// File: tb/tb_axi4_lite_master_engine.sv
// Randomized single-transaction traffic against a cycle-count model
// of the AXI4-Lite master engine (64-bit data, 16-cycle watchdog).
module tb_axi4_lite_master_engine;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic aclk = 1'b0;
  logic aresetn;
  logic busy;
  logic timeout_err;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   exp_to;

  axi4_lite_master_engine_if #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) bus ();

  axi4_lite_master_engine #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .AWCACHE       (4'h3),
    .ARCACHE       (4'h2),
    .PROT          (3'b000),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .bus        (bus),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic slv_quiet();
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_bresp   = 2'($urandom);
    bus.m_rresp   = 2'($urandom);
    bus.m_rdata   = {$urandom, $urandom};
  endtask

  task automatic cmd_junk(input bit v);
    bus.cmd_valid = v;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = {$urandom, $urandom};
    bus.cmd_wstrb = SW'($urandom);
  endtask

  // d1: AW (or AR) ready delay, d2: W ready (or R valid) delay,
  // d3: B valid delay, rr_d: cycles rsp_ready is held low.
  task automatic do_txn(input bit wr, input logic [AW-1:0] a,
      input logic [DW-1:0] d, input logic [SW-1:0] s,
      input int d1, input int d2, input int d3,
      input logic [1:0] resp, input logic [DW-1:0] rd,
      input int rr_d, input bit to_test);
    int k;
    int lat;
    int exp_lat;
    int n_aw;
    int n_w;
    int n_b;
    int n_ar;
    int n_r;
    bit bad;
    logic [DW-1:0] exp_rd;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    bad = 1'b0;
    lat = 0;
    exp_rd = wr ? '0 : rd;
    exp_lat = wr ? ((d1 > d2 ? d1 : d2) + 3 + d3) : (d1 + 3 + d2);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
    k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 20) begin
      @(negedge aclk);
      k++;
    end
    chk("cmd_ready", bus.cmd_ready, 1'b1);
    @(negedge aclk);
    cmd_junk(1'b0);
    k = 1;
    while (k <= 200 && lat == 0) begin
      if (k > 1) @(negedge aclk);
      slv_quiet();
      if (bus.rsp_valid === 1'b1) begin
        lat = k;
      end else begin
        if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad = 1'b1;
        if (bus.m_awvalid === 1'b1) begin
          n_aw++;
          if (!wr || bus.m_awaddr !== a) bad = 1'b1;
          if (n_aw > d1) bus.m_awready = 1'b1;
        end
        if (bus.m_wvalid === 1'b1) begin
          n_w++;
          if (!wr || bus.m_wdata !== d || bus.m_wstrb !== s) bad = 1'b1;
          if (n_w > d2) bus.m_wready = 1'b1;
        end
        if (bus.m_bready === 1'b1) begin
          n_b++;
          if (!wr || bus.m_awvalid || bus.m_wvalid) bad = 1'b1;
          if (n_b > d3) begin
            bus.m_bvalid = 1'b1;
            bus.m_bresp  = resp;
          end
        end
        if (bus.m_arvalid === 1'b1) begin
          n_ar++;
          if (wr || bus.m_araddr !== a) bad = 1'b1;
          if (n_ar > d1) bus.m_arready = 1'b1;
        end
        if (bus.m_rready === 1'b1) begin
          n_r++;
          if (wr || bus.m_arvalid) bad = 1'b1;
          if (n_r > d2) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = rd;
            bus.m_rresp  = resp;
          end
        end
        if (to_test && k == TO - 1) chk("to_early", timeout_err, 1'b0);
        if (to_test && k == TO + 2) chk("to_late", timeout_err, 1'b1);
      end
      k++;
    end
    chk("rsp_lat", lat, exp_lat);
    if (wr) begin
      chk("aw_cycles", n_aw, d1 + 1);
      chk("w_cycles", n_w, d2 + 1);
      chk("b_cycles", n_b, d3 + 1);
    end else begin
      chk("ar_cycles", n_ar, d1 + 1);
      chk("r_cycles", n_r, d2 + 1);
    end
    chk("rsp_write", bus.rsp_write, wr);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_resp", bus.rsp_resp, resp);
    // Hold the response; stray B/R traffic and new cmds must be ignored.
    for (int j = 0; j <= rr_d; j++) begin
      if (j > 0) @(negedge aclk);
      bus.rsp_ready = (j == rr_d);
      cmd_junk(1'b1);
      bus.m_bvalid = 1'($urandom);
      bus.m_rvalid = 1'($urandom);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== wr ||
          bus.rsp_rdata !== exp_rd || bus.rsp_resp !== resp ||
          bus.cmd_ready !== 1'b0 || bus.m_bready !== 1'b0 ||
          bus.m_rready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    @(negedge aclk);
    slv_quiet();
    cmd_junk(1'b0);
    bus.rsp_ready = 1'b0;
    chk("rsp_done", bus.rsp_valid, 1'b0);
    chk("cmd_ready_next", bus.cmd_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
    chk("protocol", bad, 1'b0);
    if (lat - 1 >= TO) exp_to = 1'b1;
    chk("timeout_err", timeout_err, exp_to);
  endtask

  initial begin
    #1000000;
    $display("FAIL sim_limit: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit wr;
    bit seen;
    int d1;
    int d2;
    int d3;
    aresetn = 1'b0;
    exp_to = 1'b0;
    bus.rsp_ready = 1'b0;
    cmd_junk(1'b0);
    slv_quiet();
    #12;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_awvalid", bus.m_awvalid, 1'b0);
    chk("rst_wvalid", bus.m_wvalid, 1'b0);
    chk("rst_arvalid", bus.m_arvalid, 1'b0);
    chk("rst_bready", bus.m_bready, 1'b0);
    chk("rst_rready", bus.m_rready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    chk("rst_rsp_resp", bus.rsp_resp, 2'b00);
    chk("rst_wstrb", bus.m_wstrb, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("awcache", bus.m_awcache, 4'h3);
    chk("arcache", bus.m_arcache, 4'h2);
    chk("awprot", bus.m_awprot, 3'b000);
    chk("arprot", bus.m_arprot, 3'b000);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    do_txn(1'b1, 32'h10, 64'hDEAD_BEEF, 8'h0F, 0, 0, 0,
           2'b00, '0, 0, 1'b0);
    do_txn(1'b0, 32'h08, '0, '0, 5, 0, 0,
           2'b10, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
    do_txn(1'b1, 32'h20, 64'h1111_2222_3333_4444, 8'hFF, 0, 3, 0,
           2'b00, '0, 0, 1'b0);
    do_txn(1'b1, 32'h24, 64'h5555_6666_7777_8888, 8'hA5, 3, 0, 1,
           2'b11, '0, 0, 1'b0);
    do_txn(1'b1, 32'h30, 64'hCAFE_F00D, 8'h3C, 1, 1, 0,
           2'b01, '0, 10, 1'b0);
    do_txn(1'b0, 32'h34, '0, '0, 0, 0, 0,
           2'b00, 64'hFEED_FACE_0BAD_CAFE, 0, 1'b0);
    do_txn(1'b1, 32'h38, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0, 0,
           2'b00, '0, 1, 1'b0);

    repeat (24) begin
      wr = 1'($urandom);
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
      d3 = wr ? $urandom_range(0, 3) : 0;
      do_txn(wr, $urandom, {$urandom, $urandom}, SW'($urandom),
             d1, d2, d3, 2'($urandom), {$urandom, $urandom},
             $urandom_range(0, 3), 1'b0);
    end

    do_txn(1'b1, 32'h50, 64'h0A0B_0C0D, 8'h0F, 0, 0, 40,
           2'b01, '0, 0, 1'b1);
    do_txn(1'b0, 32'h54, '0, '0, 1, 1, 0,
           2'b00, 64'h1234_5678, 0, 1'b0);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h40;
    bus.cmd_wdata = 64'h9999_AAAA;
    bus.cmd_wstrb = 8'hFF;
    @(negedge aclk);
    cmd_junk(1'b0);
    @(negedge aclk);
    chk("pre_rst_awvalid", bus.m_awvalid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_awvalid", bus.m_awvalid, 1'b0);
    chk("arst_wvalid", bus.m_wvalid, 1'b0);
    chk("arst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_timeout", timeout_err, 1'b0);
    exp_to = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge aclk);
      if (bus.rsp_valid !== 1'b0 || bus.m_awvalid !== 1'b0) seen = 1'b1;
    end
    chk("no_rsp_after_rst", seen, 1'b0);
    do_txn(1'b1, 32'h44, 64'h7777_0000_1234_0000, 8'hC3, 1, 2, 1,
           2'b00, '0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
